// File: rtl/sd_spi_responder.sv
// rtl/sd_spi_responder.sv - SD-card SPI-mode card-side responder (CMD0/CMD1/CMD17)
module sd_spi_responder #(
    parameter int NCR_BYTES = 1,
    parameter int NAC_BYTES = 2,
    parameter int INIT_CNT  = 2,
    parameter int BLK_LEN   = 512,
    parameter int ADDR_W    = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CS,
    input  logic              SD_CLK,
    input  logic              DI,
    output logic              DO,
    output logic              MEM_RD,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [7:0]        MEM_DATA,
    output logic              CMD_VALID,
    output logic [5:0]        CMD_IDX,
    output logic [31:0]       CMD_ARG
);
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_NCR, S_R1, S_NAC, S_TOKEN, S_DATA, S_CRC
    } state_t;

    localparam logic [15:0] NCR_LAST = 16'(NCR_BYTES - 1);
    localparam logic [15:0] NAC_LAST = 16'(NAC_BYTES - 1);
    localparam logic [15:0] BLK_LAST = 16'(BLK_LEN - 1);
    localparam logic [7:0]  INIT_MAX = 8'(INIT_CNT);

    state_t      state, next_state;
    logic [1:0]  sclk_sync, di_sync;
    logic        sclk_prev;
    // Holds frame bits 45..1 once the 47th bit is in; the end bit is never stored.
    logic [44:0] rx_sr;
    logic [5:0]  rx_cnt;
    logic [2:0]  tx_bit;
    logic [6:0]  tx_sr;
    logic [15:0] byte_cnt;
    logic [7:0]  r1_q, data_buf, init_cnt;
    logic        read_q, idle_flag, rd_d;

    logic        sclk_rise, sclk_fall, di_bit;
    logic        start_seen, frame_done, tx_state, byte_end, last_byte, fetch;
    logic [7:0]  tx_byte;
    logic [15:0] fetch_idx;
    logic [7:0]  r1_new, init_new;
    logic        idle_new, read_new;

    assign sclk_rise  = sclk_sync[1] & ~sclk_prev;
    assign sclk_fall  = ~sclk_sync[1] & sclk_prev;
    assign di_bit     = di_sync[1];
    assign start_seen = (state == S_IDLE) && sclk_rise && !rx_sr[0] && di_bit;
    assign frame_done = (state == S_CMD) && sclk_rise && (rx_cnt == 6'd47);
    assign tx_state   = (state != S_IDLE) && (state != S_CMD);
    assign byte_end   = tx_state && sclk_fall && (tx_bit == 3'd7);

    always_comb begin
        case (state)
            S_NCR:   last_byte = (byte_cnt == NCR_LAST);
            S_NAC:   last_byte = (byte_cnt == NAC_LAST);
            S_DATA:  last_byte = (byte_cnt == BLK_LAST);
            S_CRC:   last_byte = (byte_cnt == 16'd1);
            default: last_byte = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (CS) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start_seen) next_state = S_CMD;
                S_CMD:   if (frame_done) next_state = S_NCR;
                S_NCR:   if (byte_end && last_byte) next_state = S_R1;
                S_R1:    if (byte_end) next_state = (read_q && r1_q == 8'h00) ? S_NAC : S_IDLE;
                S_NAC:   if (byte_end && last_byte) next_state = S_TOKEN;
                S_TOKEN: if (byte_end) next_state = S_DATA;
                S_DATA:  if (byte_end && last_byte) next_state = S_CRC;
                S_CRC:   if (byte_end && last_byte) next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Next data byte is prefetched while the last bit of the previous byte is on the wire.
    always_comb begin
        tx_byte = 8'hFF;
        case (state)
            S_R1:    tx_byte = r1_q;
            S_TOKEN: tx_byte = 8'hFE;
            S_DATA:  tx_byte = data_buf;
            default: tx_byte = 8'hFF;
        endcase
        fetch     = byte_end && ((state == S_TOKEN) || (state == S_DATA && !last_byte));
        fetch_idx = (state == S_TOKEN) ? 16'd0 : byte_cnt + 16'd1;
    end

    always_comb begin
        r1_new   = {7'd0, idle_flag} | 8'h04;
        idle_new = idle_flag;
        init_new = init_cnt;
        read_new = 1'b0;
        case (rx_sr[44:39])
            6'd0: begin
                if (rx_sr[6:0] == 7'h4A) begin
                    idle_new = 1'b1;
                    init_new = 8'd0;
                    r1_new   = 8'h01;
                end else begin
                    r1_new   = 8'h09;
                end
            end
            6'd1: begin
                if (idle_flag && init_cnt < INIT_MAX) begin
                    init_new = init_cnt + 8'd1;
                    r1_new   = 8'h01;
                end else begin
                    idle_new = 1'b0;
                    r1_new   = 8'h00;
                end
            end
            6'd17: begin
                if (idle_flag) begin
                    r1_new   = 8'h05;
                end else begin
                    r1_new   = 8'h00;
                    read_new = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sclk_sync <= 2'b00;
            di_sync   <= 2'b11;
            sclk_prev <= 1'b0;
            rx_sr     <= '1;
            rx_cnt    <= 6'd0;
            tx_bit    <= 3'd0;
            tx_sr     <= 7'h7F;
            byte_cnt  <= 16'd0;
            r1_q      <= 8'hFF;
            read_q    <= 1'b0;
            data_buf  <= 8'h00;
            rd_d      <= 1'b0;
            idle_flag <= 1'b1;
            init_cnt  <= 8'd0;
            DO        <= 1'b1;
            MEM_RD    <= 1'b0;
            MEM_ADDR  <= '0;
            CMD_VALID <= 1'b0;
            CMD_IDX   <= 6'd0;
            CMD_ARG   <= 32'd0;
        end else begin
            sclk_sync <= {sclk_sync[0], SD_CLK};
            di_sync   <= {di_sync[0], DI};
            sclk_prev <= sclk_sync[1];
            CMD_VALID <= 1'b0;
            MEM_RD    <= 1'b0;
            rd_d      <= MEM_RD;
            if (rd_d) data_buf <= MEM_DATA;

            if (CS) begin
                DO       <= 1'b1;
                rx_sr    <= '1;
                rx_cnt   <= 6'd0;
                tx_bit   <= 3'd0;
                byte_cnt <= 16'd0;
            end else if (tx_state) begin
                rx_sr <= '1;
                if (sclk_fall) begin
                    tx_bit <= tx_bit + 3'd1;
                    if (tx_bit == 3'd0) begin
                        DO    <= tx_byte[7];
                        tx_sr <= tx_byte[6:0];
                    end else begin
                        DO    <= tx_sr[6];
                        tx_sr <= {tx_sr[5:0], 1'b1};
                    end
                end
                if (byte_end) byte_cnt <= last_byte ? 16'd0 : byte_cnt + 16'd1;
                if (fetch) begin
                    MEM_RD   <= 1'b1;
                    MEM_ADDR <= ADDR_W'(CMD_ARG) + ADDR_W'(fetch_idx);
                end
            end else begin
                if (sclk_fall) DO <= 1'b1;
                if (sclk_rise) begin
                    rx_sr  <= {rx_sr[43:0], di_bit};
                    rx_cnt <= (state == S_CMD) ? rx_cnt + 6'd1 : (start_seen ? 6'd2 : 6'd0);
                end
                if (frame_done) begin
                    CMD_VALID <= 1'b1;
                    CMD_IDX   <= rx_sr[44:39];
                    CMD_ARG   <= rx_sr[38:7];
                    r1_q      <= r1_new;
                    read_q    <= read_new;
                    idle_flag <= idle_new;
                    init_cnt  <= init_new;
                    tx_bit    <= 3'd0;
                    byte_cnt  <= 16'd0;
                end
            end
        end
    end
endmodule
